// File: rtl/firtap_mc_if.sv
// Chained FIR tap bus: coefficient shift chain, commit control, sample/partial-sum path.
// Flow is strobe-driven by i_ce; there is no backpressure.
interface firtap_mc_if #(
    parameter int IW  = 16,
    parameter int TW  = IW,
    parameter int OW  = IW + TW + 8,
    parameter int NCH = 1
);
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

    logic           i_tap_wr;
    logic [TW-1:0]  i_tap;
    logic [TW-1:0]  o_tap;
    logic           i_tap_commit;
    logic [TW-1:0]  o_coef;
    logic           o_commit_pending;
    logic           i_ce;
    logic [IW-1:0]  i_sample;
    logic [IW-1:0]  o_sample;
    logic [OW-1:0]  i_partial_acc;
    logic [OW-1:0]  o_acc;
    logic [CHW-1:0] o_chan;

    modport slave (
        input  i_tap_wr, i_tap, i_tap_commit, i_ce, i_sample, i_partial_acc,
        output o_tap, o_coef, o_commit_pending, o_sample, o_acc, o_chan
    );

    modport master (
        output i_tap_wr, i_tap, i_tap_commit, i_ce, i_sample, i_partial_acc,
        input  o_tap, o_coef, o_commit_pending, o_sample, o_acc, o_chan
    );
endinterface

// File: rtl/firtap_mc.sv
// Multichannel systolic FIR tap: product after 1 strobe, o_acc after 2, o_sample after NCH+1.
// Advances only on i_ce (no backpressure); shadow/active coefficient swaps at frame boundaries.
module firtap_mc #(
    parameter int              IW            = 16,
    parameter int              TW            = IW,
    parameter int              OW            = IW + TW + 8,
    parameter int              NCH           = 1,
    parameter bit              FIXED_TAPS    = 1'b0,
    parameter logic [TW-1:0]   INITIAL_VALUE = '0,
    parameter bit              OPT_SATURATE  = 1'b0
) (
    input  logic        i_clk,
    input  logic        i_reset,
    firtap_mc_if.slave  bus
);
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int PW  = TW + IW;

    logic [CHW-1:0]        chan_q, chan_d;
    logic                  last_ch;
    logic [IW-1:0]         dly_q [0:NCH];
    logic [TW-1:0]         coef_w;
    logic signed [PW-1:0]  prod_q, prod_d;
    logic signed [OW-1:0]  part_w, prod_ext, sum_w, acc_d, acc_q;
    logic                  ovf;

    assign last_ch = (chan_q == CHW'(NCH - 1));
    assign chan_d  = last_ch ? '0 : chan_q + CHW'(1);
    assign prod_d  = PW'($signed(coef_w)) * PW'($signed(bus.i_sample));

    always_comb begin
        part_w   = $signed(bus.i_partial_acc);
        prod_ext = OW'(prod_q);
        sum_w    = part_w + prod_ext;
        ovf      = (part_w[OW-1] == prod_ext[OW-1]) && (sum_w[OW-1] != part_w[OW-1]);
        acc_d    = sum_w;
        if (OPT_SATURATE && ovf)
            acc_d = part_w[OW-1] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}};
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int k = 0; k <= NCH; k++) dly_q[k] <= '0;
            chan_q <= '0;
            prod_q <= '0;
            acc_q  <= '0;
        end else if (bus.i_ce) begin
            dly_q[0] <= bus.i_sample;
            for (int k = 1; k <= NCH; k++) dly_q[k] <= dly_q[k-1];
            chan_q <= chan_d;
            prod_q <= prod_d;
            acc_q  <= acc_d;
        end
    end

    assign bus.o_sample = dly_q[NCH];
    assign bus.o_acc    = acc_q;
    assign bus.o_chan   = chan_q;
    assign bus.o_coef   = coef_w;

    if (FIXED_TAPS) begin : g_fixed
        assign coef_w               = bus.i_tap;
        assign bus.o_tap            = bus.i_tap;
        assign bus.o_commit_pending = 1'b0;
    end else begin : g_shadow
        logic [TW-1:0] shadow_q, shadow_d, active_q, active_d;
        logic          pend_q, pend_d, apply_w;

        // The swap takes the shadow as it was before any same-cycle write.
        always_comb begin
            apply_w  = bus.i_ce && last_ch && (pend_q || bus.i_tap_commit);
            shadow_d = bus.i_tap_wr ? bus.i_tap : shadow_q;
            active_d = apply_w ? shadow_q : active_q;
            pend_d   = apply_w ? 1'b0 : (pend_q | bus.i_tap_commit);
        end

        always_ff @(posedge i_clk or posedge i_reset) begin
            if (i_reset) begin
                shadow_q <= INITIAL_VALUE;
                active_q <= INITIAL_VALUE;
                pend_q   <= 1'b0;
            end else begin
                shadow_q <= shadow_d;
                active_q <= active_d;
                pend_q   <= pend_d;
            end
        end

        assign coef_w               = active_q;
        assign bus.o_tap            = shadow_q;
        assign bus.o_commit_pending = pend_q;
    end
endmodule

// File: doc/firtap_mc.md
Name: firtap_mc

Overview:
Next-generation systolic FIR tap: multiply-accumulate stage for strings of N taps forming a 1-sample-per-clock FIR, now supporting NCH time-interleaved channels. Adds a double-buffered (shadow/active) coefficient with frame-aligned commit, and optional saturating accumulation. Sits inside the generic FIR chain: sample, coefficient and partial-sum ports chain tap to tap.

Parameters:
IW, 16, input sample width (signed)
TW, IW, coefficient width (signed)
OW, IW+TW+8, accumulator width (signed)
NCH, 1, number of interleaved channels (>=1)
FIXED_TAPS, 0, 1: active coefficient is i_tap directly; shadow, commit and pending logic absent
INITIAL_VALUE, 0, TW-bit reset value of shadow and active coefficient
OPT_SATURATE, 0, 1: accumulate saturates at OW signed limits; 0: wraps modulo 2^OW

Ports:
i_clk  in  1  clock, all state on rising edge
i_reset  in  1  asynchronous, active-high reset
i_tap_wr  in  1  shift-chain strobe: shadow <= i_tap
i_tap  in  TW  coefficient in (from previous tap's o_tap, or fixed value)
o_tap  out  TW  shadow coefficient (FIXED_TAPS: equals i_tap)
i_tap_commit  in  1  request shadow -> active copy at next frame boundary
o_coef  out  TW  active coefficient used by multiplier
o_commit_pending  out  1  commit requested, not yet applied
i_ce  in  1  sample strobe; one channel per strobe, channel order 0..NCH-1
i_sample  in  IW  signed sample in
o_sample  out  IW  sample delayed NCH+1 strobes, to next tap
i_partial_acc  in  OW  partial sum from previous tap
o_acc  out  OW  partial sum to next tap
o_chan  out  max(1,$clog2(NCH))  channel index of current i_ce sample

Behaviour:
- Reset (async): delay line, product, o_acc, o_sample, o_chan = 0; shadow and active = INITIAL_VALUE; o_commit_pending = 0. Reset mid-frame discards all in-flight samples; channel counter restarts at 0.
- Nothing but shadow write and commit latch changes when i_ce = 0.
- Channel counter: increments on i_ce, wraps NCH-1 -> 0. NCH=1: constant 0.
- Sample path: shift register of depth NCH+1 advanced by i_ce; o_sample = i_sample from NCH+1 strobes earlier. (Sample delay NCH+1 vs. accumulator delay 1 gives relative delay of one same-channel sample per tap.)
- Product: on i_ce, product <= o_coef * i_sample, signed, full TW+IW bits.
- Accumulate: on i_ce, o_acc <= i_partial_acc + sign-extend(product) to OW. Thus o_acc after strobe k = i_partial_acc(k) + coef*i_sample(k-1).
- OPT_SATURATE=1: if both operands share a sign and result sign differs, o_acc = 2^(OW-1)-1 (positive) or -2^(OW-1) (negative). Otherwise wrap.
- Shadow: i_tap_wr copies i_tap to shadow every clock it is high, independent of i_ce.
- Commit: i_tap_commit sets pending. On the first i_ce with channel counter = NCH-1 while pending: active <= shadow (value before any same-cycle write); pending clears. The new coefficient is first used by the channel-0 product of the next frame.
- Commit arriving on the same cycle as a boundary strobe: applied at that boundary. Repeated commits while pending: no extra effect.
- FIXED_TAPS=1: o_coef = o_tap = i_tap combinationally; o_commit_pending = 0.

Test Plan:
- Impulse, NCH=1, active coef 3: i_sample 1 then 0s, i_partial_acc=0, continuous i_ce -> o_acc = 3 on the 2nd strobe only; o_sample = 1 on the 2nd strobe.
- NCH=4, coef 2: samples ch0..3 = 10,20,30,40, then 0s -> o_acc 20,40,60,80 on strobes 2-5; o_sample returns 10 five strobes after input; o_chan cycles 0,1,2,3.
- Commit alignment, NCH=4: write shadow=5 and assert commit at ch1 -> pending=1 until ch3 strobe; products use 2 through ch3, 5 from next ch0.
- Saturation, OW=8, IW=TW=4 (OPT_SATURATE=1): partial 120, coef 7, sample 7 -> o_acc = 127; partial -120, coef 7, sample -8 -> -128; OPT_SATURATE=0 -> wraps to -87 and 80.
- Stall: i_ce deasserted 5 cycles mid-stream -> o_acc, o_sample, o_chan hold; results identical to an unstalled run.
- Async reset mid-frame with pending commit -> all outputs 0 immediately (before next edge); coef = INITIAL_VALUE; pending = 0; o_chan = 0.
